// File: rtl/square_generic.sv
// -----------------------------------------------------------------------------
// square_generic
//
// Fully pipelined unsigned integer squarer: square = operand * operand.
// It runs the MSB-first square-root digit recurrence forwards. Each of the
// WIDTH_INPUT register stages folds in one more operand bit, so the partial
// root grows by one bit per stage. The partial square is kept equal to the
// partial root squared, using the identity (2r + b)^2 = 4r^2 + b*(4r + 1).
//
// One operand is accepted per cycle. Results leave in order after exactly
// WIDTH_INPUT cycles. There is no stall and no backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every stage
//   valid_in   qualifies operand in the current cycle
//   operand    unsigned value to square, WIDTH_INPUT bits
//   valid_out  square holds the result for the operand accepted WIDTH_INPUT
//              cycles earlier
//   square     unsigned square, WIDTH_OUTPUT (= 2*WIDTH_INPUT) bits
// -----------------------------------------------------------------------------
module square_generic #(
  parameter int WIDTH_INPUT  = 8,
  parameter int WIDTH_OUTPUT = 2 * WIDTH_INPUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [WIDTH_INPUT-1:0]  operand,
  output logic                    valid_out,
  output logic [WIDTH_OUTPUT-1:0] square
);

  localparam int N  = WIDTH_INPUT;
  localparam int W2 = WIDTH_OUTPUT;
  // The last stage only needs the square. Partial root and unconsumed bits
  // therefore exist for stages 0..N-2 only. One dummy entry is kept when N=1
  // so the arrays never become zero-sized.
  localparam int NC = (N > 1) ? (N - 1) : 1;

  // Partial root of stage k: the top k+1 operand bits, right-aligned.
  logic [N-1:0]  root_q [NC];
  logic [N-1:0]  root_d [NC];
  // Unconsumed operand bits, left-aligned so the next bit is always the MSB.
  logic [N-1:0]  rest_q [NC];
  logic [N-1:0]  rest_d [NC];
  // Partial square of stage k, equal to root_k squared.
  logic [W2-1:0] sq_q   [N];
  logic [W2-1:0] sq_d   [N];
  // Valid bit travelling alongside the data.
  logic          vld_q  [N];
  logic          vld_d  [N];

  logic          step_bit;
  logic [W2-1:0] root_ext;

  // Next-state logic for every pipeline stage.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      sq_d[k]  = '0;
      vld_d[k] = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      root_d[k] = '0;
      rest_d[k] = '0;
    end
    step_bit = 1'b0;
    root_ext = '0;

    // Stage 0: root and square both equal the operand MSB (0 or 1).
    sq_d[0]  = W2'(operand[N-1]);
    vld_d[0] = valid_in;
    if (N > 1) begin
      root_d[0] = N'(operand[N-1]);
      rest_d[0] = operand << 1'b1;
    end else begin
      root_d[0] = '0;
      rest_d[0] = '0;
    end

    // Stages 1..N-1: s_k = 4*s_{k-1} + (b ? 4*r_{k-1} + 1 : 0).
    for (int k = 1; k < N; k++) begin
      step_bit = rest_q[k-1][N-1];
      root_ext = W2'(root_q[k-1]);
      if (step_bit) begin
        sq_d[k] = (sq_q[k-1] << 2'd2) + (root_ext << 2'd2) + W2'(1'b1);
      end else begin
        sq_d[k] = sq_q[k-1] << 2'd2;
      end
      vld_d[k] = vld_q[k-1];
    end

    // Stages 1..N-2 also extend the partial root and consume one more bit.
    for (int k = 1; k < NC; k++) begin
      step_bit  = rest_q[k-1][N-1];
      root_d[k] = (root_q[k-1] << 1'b1) | N'(step_bit);
      rest_d[k] = rest_q[k-1] << 1'b1;
    end
  end

  // Pipeline registers; reset flushes every in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        sq_q[k]  <= '0;
        vld_q[k] <= 1'b0;
      end
      for (int k = 0; k < NC; k++) begin
        root_q[k] <= '0;
        rest_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        sq_q[k]  <= sq_d[k];
        vld_q[k] <= vld_d[k];
      end
      for (int k = 0; k < NC; k++) begin
        root_q[k] <= root_d[k];
        rest_q[k] <= rest_d[k];
      end
    end
  end

  assign square    = sq_q[N-1];
  assign valid_out = vld_q[N-1];

endmodule

// File: tb/tb_square_generic.sv
module tb_square_generic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vin8,  vout8;
  logic [7:0]  op8;
  logic [15:0] sq8;
  logic        vin5,  vout5;
  logic [4:0]  op5;
  logic [9:0]  sq5;
  logic        vin1,  vout1;
  logic [0:0]  op1;
  logic [1:0]  sq1;

  square_generic #(.WIDTH_INPUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin8), .operand(op8),
    .valid_out(vout8), .square(sq8));
  square_generic #(.WIDTH_INPUT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin5), .operand(op5),
    .valid_out(vout5), .square(sq5));
  square_generic #(.WIDTH_INPUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(vin1), .operand(op1),
    .valid_out(vout1), .square(sq1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] sq;
    logic [7:0]  x;
    int          due;
  } exp_t;
  exp_t sb[$];

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard monitor for the 8-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    if (rst_n === 1'b1) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check("valid_out", 32'(vout8), 32'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        if (vout8 === 1'b1) begin
          check("square", 32'(sq8), 32'(e.sq));
          check("roundtrip_sqrt", 32'(isqrt(int'(sq8))), 32'(e.x));
        end
      end
    end
  end

  task automatic send8(input logic [7:0] x);
    exp_t e;
    @(posedge clk);
    #1;
    vin8  = 1'b1;
    op8   = x;
    e.sq  = 16'(x) * 16'(x);
    e.x   = x;
    e.due = cyc + 8;
    sb.push_back(e);
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vin8 = 1'b0;
      op8  = 8'($urandom);
    end
  endtask

  initial begin
    logic [7:0] iso_ops [5];
    iso_ops = '{8'd0, 8'd1, 8'd15, 8'd16, 8'd255};

    rst_n = 1'b0;
    vin8 = 1'b0; op8 = 8'd0;
    vin5 = 1'b0; op5 = 5'd0;
    vin1 = 1'b0; op1 = 1'b0;

    // Reset state of all three instances.
    #2;
    check("rst_valid8",  32'(vout8), 32'd0);
    check("rst_square8", 32'(sq8),   32'd0);
    check("rst_valid5",  32'(vout5), 32'd0);
    check("rst_square5", 32'(sq5),   32'd0);
    check("rst_valid1",  32'(vout1), 32'd0);
    check("rst_square1", 32'(sq1),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Isolated operands.
    for (int i = 0; i < 5; i++) begin
      send8(iso_ops[i]);
      idle8(10);
    end

    // Full back-to-back stream 0..255.
    for (int i = 0; i < 256; i++) send8(8'(i));
    idle8(10);

    // Bubble pattern 1,0,0,1,1,0,1.
    send8(8'd3);
    idle8(2);
    send8(8'd200);
    send8(8'd201);
    idle8(1);
    send8(8'd128);
    idle8(10);

    // Reset while 5 operands are in flight and one result is on the output.
    for (int i = 0; i < 10; i++) send8(8'(i + 50));
    idle8(2);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(vout8), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_valid",  32'(vout8), 32'd0);
    check("async_rst_square", 32'(sq8),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle8(1);
    send8(8'd100);
    idle8(12);

    // 5-bit instance: 31 then 17 back to back, latency 5.
    @(posedge clk); #1; vin5 = 1'b1; op5 = 5'd31;
    @(posedge clk); #1; op5 = 5'd17;
    @(posedge clk); #1; vin5 = 1'b0; op5 = 5'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("n5_early_valid", 32'(vout5), 32'd0);
    @(negedge clk);
    check("n5_valid_a",  32'(vout5), 32'd1);
    check("n5_square_a", 32'(sq5),   32'd961);
    @(negedge clk);
    check("n5_valid_b",  32'(vout5), 32'd1);
    check("n5_square_b", 32'(sq5),   32'd289);
    @(negedge clk);
    check("n5_late_valid", 32'(vout5), 32'd0);

    // 1-bit instance: operand 1 then 0, latency 1.
    @(posedge clk); #1; vin1 = 1'b1; op1 = 1'b1;
    @(negedge clk);
    check("n1_early_valid", 32'(vout1), 32'd0);
    @(posedge clk); #1;
    check("n1_valid_a",  32'(vout1), 32'd1);
    check("n1_square_a", 32'(sq1),   32'd1);
    op1 = 1'b0;
    @(posedge clk); #1;
    check("n1_valid_b",  32'(vout1), 32'd1);
    check("n1_square_b", 32'(sq1),   32'd0);
    vin1 = 1'b0;
    @(posedge clk); #1;
    check("n1_late_valid", 32'(vout1), 32'd0);

    idle8(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
